// File: rtl/jgate_pkg.sv
// jgate_pkg: shared types for the jgate gate datapath.
//   op_t : 2-bit operation select (AND, OR, NOT of a, NAND).
package jgate_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_NOT  = 2'd2,
        OP_NAND = 2'd3
    } op_t;

endpackage

// File: rtl/jgate_if.sv
// jgate_if: operand/result bundle of jgate_unit.
//   in_valid, op, a, b : request side (driven by master)
//   y, out_valid       : registered result (driven by slave)
//   y_all, y_any       : reduce outputs, present only when JGATE_REDUCE_EN is defined
// Modports: master (requester), slave (jgate_unit).
interface jgate_if #(
    parameter int unsigned WIDTH = 8
);
    import jgate_pkg::*;

    logic             in_valid;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic             out_valid;
`ifdef JGATE_REDUCE_EN
    logic             y_all;
    logic             y_any;
`endif

    modport master (
        output in_valid,
        output op,
        output a,
        output b,
        input  y,
`ifdef JGATE_REDUCE_EN
        input  y_all,
        input  y_any,
`endif
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  op,
        input  a,
        input  b,
        output y,
`ifdef JGATE_REDUCE_EN
        output y_all,
        output y_any,
`endif
        output out_valid
    );

endinterface

// File: rtl/jand.sv
// jand: primitive 2-input AND gate.
//   a, b : inputs
//   c    : a & b
module jand (
    input  logic a,
    input  logic b,
    output logic c
);

    assign c = a & b;

endmodule

// File: rtl/jgate_bit.sv
// jgate_bit: one bit slice of the gate datapath.
//   a, b : operand bits (b unused for NOT)
//   op   : operation select
//   d    : combinational result bit, f(op, a, b)
module jgate_bit
    import jgate_pkg::*;
(
    input  logic a,
    input  logic b,
    input  op_t  op,
    output logic d
);

    logic and_c;
    logic or_c;
    logic not_a;
    logic nand_c;

    jand u_and (
        .a (a),
        .b (b),
        .c (and_c)
    );

    jor u_or (
        .a (a),
        .b (b),
        .c (or_c)
    );

    jnot u_not_a (
        .a (a),
        .b (not_a)
    );

    jnot u_nand (
        .a (and_c),
        .b (nand_c)
    );

    always_comb begin
        d = 1'b0;
        unique case (op)
            OP_AND:  d = and_c;
            OP_OR:   d = or_c;
            OP_NOT:  d = not_a;
            OP_NAND: d = nand_c;
            default: d = 1'b0;
        endcase
    end

endmodule

// File: rtl/jnot.sv
// jnot: primitive inverter.
//   a : input
//   b : ~a
module jnot (
    input  logic a,
    output logic b
);

    assign b = ~a;

endmodule

// File: rtl/jor.sv
// jor: primitive 2-input OR gate.
//   a, b : inputs
//   c    : a | b
module jor (
    input  logic a,
    input  logic b,
    output logic c
);

    assign c = a | b;

endmodule

// File: rtl/jgate_unit.sv
// jgate_unit: registered bitwise gate unit (AND / OR / NOT a / NAND).
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   bus   : jgate_if slave (in_valid, op, a, b -> y, out_valid [, y_all, y_any])
// Result latency is one cycle; no backpressure.
// Build option: JGATE_REDUCE_EN adds registered AND/OR reductions of y (y_all, y_any).
module jgate_unit
    import jgate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic   clk,
    input  logic   reset,
    jgate_if.slave bus
);

    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic             out_valid_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jgate_bit u_bit (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .op (bus.op),
            .d  (y_d[i])
        );
    end

`ifdef JGATE_REDUCE_EN
    // Reductions are taken from the next y value so they register in the same cycle as y.
    logic [WIDTH-1:0] all_chain;
    logic [WIDTH-1:0] any_chain;
    logic             all_d;
    logic             any_d;
    logic             y_all_q;
    logic             y_any_q;

    assign all_chain[0] = y_d[0];
    assign any_chain[0] = y_d[0];

    for (genvar i = 1; i < WIDTH; i++) begin : g_reduce
        jand u_all (
            .a (all_chain[i-1]),
            .b (y_d[i]),
            .c (all_chain[i])
        );

        jor u_any (
            .a (any_chain[i-1]),
            .b (y_d[i]),
            .c (any_chain[i])
        );
    end

    assign all_d = all_chain[WIDTH-1];
    assign any_d = any_chain[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            y_all_q <= 1'b0;
            y_any_q <= 1'b0;
        end else if (bus.in_valid) begin
            y_all_q <= all_d;
            y_any_q <= any_d;
        end
    end

    assign bus.y_all = y_all_q;
    assign bus.y_any = y_any_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                y_q <= y_d;
            end
            out_valid_q <= bus.in_valid;
        end
    end

    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_jgate_unit.sv
// tb_jgate_unit: self-checking bench for jgate_unit (WIDTH=8), directed steps then random traffic
// checked against a bitwise reference model.
module tb_jgate_unit;
    import jgate_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset;

    jgate_if #(.WIDTH(W)) bus ();

    jgate_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [W-1:0] exp_y;
    logic         exp_valid;

    function automatic logic [W-1:0] ref_op(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            0:       return a & b;
            1:       return a | b;
            2:       return ~a;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, and compare after the edge.
    task automatic step(input string tag, input logic rst, input logic v, input int o,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        reset        = rst;
        bus.in_valid = v;
        bus.op       = op_t'(o[1:0]);
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        if (rst) begin
            exp_y     = '0;
            exp_valid = 1'b0;
        end else if (v) begin
            exp_y     = ref_op(o, a, b);
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        #1;
        check({tag, ".y"}, 32'(bus.y), 32'(exp_y));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_valid));
`ifdef JGATE_REDUCE_EN
        check({tag, ".y_all"}, 32'(bus.y_all), 32'(&exp_y));
        check({tag, ".y_any"}, 32'(bus.y_any), 32'(|exp_y));
`endif
    endtask

    initial begin
        exp_y     = '0;
        exp_valid = 1'b0;

        // Reset dominates a valid request
        step("rst0", 1'b1, 1'b1, 0, 8'hFF, 8'hFF);
        step("rst1", 1'b1, 1'b1, 0, 8'hFF, 8'hFF);
        check("rst_y_const", 32'(bus.y), 32'h00);

        // Basic ops
        step("and", 1'b0, 1'b1, 0, 8'hF0, 8'h3C);
        check("and_y_const", 32'(bus.y), 32'h30);
        step("or", 1'b0, 1'b1, 1, 8'hF0, 8'h3C);
        check("or_y_const", 32'(bus.y), 32'hFC);
        step("not", 1'b0, 1'b1, 2, 8'hF0, 8'hAA);
        check("not_y_const", 32'(bus.y), 32'h0F);
        step("nand", 1'b0, 1'b1, 3, 8'hFF, 8'hFF);
        check("nand_y_const", 32'(bus.y), 32'h00);

        // Hold when idle
        step("hold_acc", 1'b0, 1'b1, 0, 8'h0F, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            step("hold_idle", 1'b0, 1'b0, 1, 8'hAA, 8'h55);
        end
        check("hold_y_const", 32'(bus.y), 32'h0F);

        // Reset mid-stream discards the op, next accept is normal
        step("rst_mid", 1'b1, 1'b1, 1, 8'h01, 8'h00);
        step("post_rst", 1'b0, 1'b1, 1, 8'h01, 8'h02);
        check("post_rst_const", 32'(bus.y), 32'h03);

        // Reduce corner cases
        step("red_ff", 1'b0, 1'b1, 2, 8'h00, 8'h00);
        step("red_80", 1'b0, 1'b1, 0, 8'h80, 8'h80);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)), W'($urandom), W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
